// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between a command FIFO (ch0) and a bulk FIFO (ch1).
// One word per frame: pop, fetch, load, wait for the frame to finish, then hold off for gap_cycles.
module uart_tx_arbiter #(
   parameter int DATA_WIDTH = 16,
   parameter int GAP_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [GAP_WIDTH-1:0]  gap_cycles,
   input  logic                  ch0_empty,
   input  logic [DATA_WIDTH-1:0] ch0_data,
   output logic                  ch0_rd_en,
   input  logic                  ch1_empty,
   input  logic [DATA_WIDTH-1:0] ch1_data,
   output logic                  ch1_rd_en,
   input  logic                  tx_busy,
   output logic                  tx_wr_en,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  grant,
   output logic                  active,
   output logic [15:0]           frame_count,
   output logic                  tx_error
);

   typedef enum logic [2:0] {IDLE, POP, FETCH, LOAD, WAIT_BUSY, WAIT_DONE, GAP} state_t;

   state_t                state_q, state_d;
   logic                  ch0_rd_en_q, ch0_rd_en_d;
   logic                  ch1_rd_en_q, ch1_rd_en_d;
   logic                  tx_wr_en_q, tx_wr_en_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  grant_q, grant_d;
   logic                  last_q, last_d;
   logic [15:0]           frame_count_q, frame_count_d;
   logic                  tx_error_q, tx_error_d;
   logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
   logic                  busy_cnt_q, busy_cnt_d;
   logic                  pick;

   // Strobes are computed one state early so they are registered and line up with POP/LOAD.
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can infer a latch.
      state_d       = state_q;
      ch0_rd_en_d   = 1'b0;
      ch1_rd_en_d   = 1'b0;
      tx_wr_en_d    = 1'b0;
      tx_data_d     = tx_data_q;
      grant_d       = grant_q;
      last_d        = last_q;
      frame_count_d = frame_count_q;
      tx_error_d    = tx_error_q;
      gap_cnt_d     = gap_cnt_q;
      busy_cnt_d    = busy_cnt_q;
      pick          = (!ch0_empty && !ch1_empty) ? ~last_q : ch0_empty;

      case (state_q)
         IDLE: begin
            if (en && (!ch0_empty || !ch1_empty)) begin
               grant_d     = pick;
               last_d      = pick;
               ch0_rd_en_d = ~pick;
               ch1_rd_en_d = pick;
               state_d     = POP;
            end
         end
         POP: state_d = FETCH;
         FETCH: begin
            tx_data_d     = grant_q ? ch1_data : ch0_data;
            tx_wr_en_d    = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = LOAD;
         end
         LOAD: begin
            busy_cnt_d = 1'b0;
            state_d    = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (busy_cnt_q) begin
               tx_error_d = 1'b1;
               gap_cnt_d  = gap_cycles;
               state_d    = GAP;
            end else begin
               busy_cnt_d = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               gap_cnt_d = gap_cycles;
               state_d   = GAP;
            end
         end
         GAP: begin
            // A latched gap of 0 or 1 both leave after a single GAP cycle.
            if (gap_cnt_q == '0 || gap_cnt_q == GAP_WIDTH'(1)) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only; reset is synchronous and active-low.
      if (!rst) begin
         state_q       <= IDLE;
         ch0_rd_en_q   <= 1'b0;
         ch1_rd_en_q   <= 1'b0;
         tx_wr_en_q    <= 1'b0;
         tx_data_q     <= '0;
         grant_q       <= 1'b0;
         last_q        <= 1'b1;
         frame_count_q <= '0;
         tx_error_q    <= 1'b0;
         gap_cnt_q     <= '0;
         busy_cnt_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch0_rd_en_q   <= ch0_rd_en_d;
         ch1_rd_en_q   <= ch1_rd_en_d;
         tx_wr_en_q    <= tx_wr_en_d;
         tx_data_q     <= tx_data_d;
         grant_q       <= grant_d;
         last_q        <= last_d;
         frame_count_q <= frame_count_d;
         tx_error_q    <= tx_error_d;
         gap_cnt_q     <= gap_cnt_d;
         busy_cnt_q    <= busy_cnt_d;
      end
   end

   assign ch0_rd_en   = ch0_rd_en_q;
   assign ch1_rd_en   = ch1_rd_en_q;
   assign tx_wr_en    = tx_wr_en_q;
   assign tx_data     = tx_data_q;
   assign grant       = grant_q;
   assign frame_count = frame_count_q;
   assign tx_error    = tx_error_q;
   assign active      = (state_q != IDLE);

endmodule
